hc_ccip_mem_responder: RTL

Host-memory responder for the CCI-P interface; it is the far end of the accelerator-side requestor that issues c0 reads and c1 writes. It accepts c0 read and c1 write requests into bounded queues and services them from an internal cache-line memory. It returns c0 read-data responses and c1 write-completion responses after fixed minimum latencies, and drives c0TxAlmFull/c1TxAlmFull backpressure. It is used in simulation and emulation builds in place of the FIU/host, so requestor logic runs unmodified.

---
 rtl/hc_ccip_mem_responder.sv | 274 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/hc_ccip_mem_responder.sv
// rtl/hc_ccip_mem_responder.sv - CCI-P host memory responder standing in for the FIU/host
//
// Purpose: accepts c0 read and c1 write requests, services them from an internal
// cache-line memory, and returns c0 read data / c1 write completions after fixed
// minimum latencies, with registered almost-full backpressure.
//
// Ports:
//   clk             clock
//   reset           asynchronous, active-high reset
//   ccip_c0_tx      read requests (hdr.address, hdr.mdata, hdr.cl_len, valid)
//   ccip_c1_tx      write requests (hdr.address, hdr.mdata, hdr.cl_len, data, valid)
//   ccip_rx         c0/c1 responses and c0TxAlmFull/c1TxAlmFull
//   rd_outstanding  registered read queue occupancy
//   err_overflow    sticky: a request arrived while its queue was full
//   err_cl_len      sticky: a request carried cl_len != eCL_LEN_1

package ccip_if_pkg;
    typedef logic [41:0]  t_ccip_clAddr;
    typedef logic [511:0] t_ccip_clData;
    typedef logic [15:0]  t_ccip_mdata;

    typedef enum logic [1:0] {
        eCL_LEN_1 = 2'b00,
        eCL_LEN_2 = 2'b01,
        eCL_LEN_4 = 2'b11
    } t_ccip_clLen;

    typedef enum logic [3:0] {
        eRSP_RDLINE = 4'h0,
        eRSP_UMSG   = 4'h4
    } t_ccip_c0_rsp;

    typedef enum logic [3:0] {
        eRSP_WRLINE  = 4'h0,
        eRSP_WRFENCE = 4'h4
    } t_ccip_c1_rsp;

    typedef struct packed {
        logic [1:0]   vc_sel;
        t_ccip_clLen  cl_len;
        logic [3:0]   req_type;
        t_ccip_clAddr address;
        t_ccip_mdata  mdata;
    } t_ccip_c0_ReqMemHdr;

    typedef struct packed {
        logic [1:0]   vc_sel;
        logic         sop;
        t_ccip_clLen  cl_len;
        logic [3:0]   req_type;
        t_ccip_clAddr address;
        t_ccip_mdata  mdata;
    } t_ccip_c1_ReqMemHdr;

    typedef struct packed {
        logic [1:0]   vc_used;
        logic         hit_miss;
        logic [1:0]   cl_num;
        t_ccip_c0_rsp resp_type;
        t_ccip_mdata  mdata;
    } t_ccip_c0_RspMemHdr;

    typedef struct packed {
        logic [1:0]   vc_used;
        logic         hit_miss;
        logic         format;
        logic [1:0]   cl_num;
        t_ccip_c1_rsp resp_type;
        t_ccip_mdata  mdata;
    } t_ccip_c1_RspMemHdr;

    typedef struct packed {
        t_ccip_c0_ReqMemHdr hdr;
        logic               valid;
    } t_if_ccip_c0_Tx;

    typedef struct packed {
        t_ccip_c1_ReqMemHdr hdr;
        t_ccip_clData       data;
        logic               valid;
    } t_if_ccip_c1_Tx;

    typedef struct packed {
        t_ccip_c0_RspMemHdr hdr;
        t_ccip_clData       data;
        logic               rspValid;
        logic               mmioRdValid;
        logic               mmioWrValid;
    } t_if_ccip_c0_Rx;

    typedef struct packed {
        t_ccip_c1_RspMemHdr hdr;
        logic               rspValid;
    } t_if_ccip_c1_Rx;

    typedef struct packed {
        logic           c0TxAlmFull;
        logic           c1TxAlmFull;
        t_if_ccip_c0_Rx c0;
        t_if_ccip_c1_Rx c1;
    } t_if_ccip_Rx;
endpackage

module hc_ccip_mem_responder
    import ccip_if_pkg::*;
#(
    parameter int MEM_ADDR_BITS  = 10,
    parameter int RD_FIFO_DEPTH  = 32,
    parameter int WR_FIFO_DEPTH  = 32,
    parameter int RD_LATENCY     = 8,
    parameter int WR_LATENCY     = 4,
    parameter int ALMFULL_MARGIN = 8
) (
    input  logic                           clk,
    input  logic                           reset,
    input  t_if_ccip_c0_Tx                 ccip_c0_tx,
    input  t_if_ccip_c1_Tx                 ccip_c1_tx,
    output t_if_ccip_Rx                    ccip_rx,
    output logic [$clog2(RD_FIFO_DEPTH):0] rd_outstanding,
    output logic                           err_overflow,
    output logic                           err_cl_len
);
    localparam int RD_PTR_W = $clog2(RD_FIFO_DEPTH);
    localparam int WR_PTR_W = $clog2(WR_FIFO_DEPTH);
    localparam int RD_CNT_W = RD_PTR_W + 1;
    localparam int WR_CNT_W = WR_PTR_W + 1;

    localparam logic [RD_CNT_W-1:0] RD_FULL_CNT = RD_CNT_W'(RD_FIFO_DEPTH);
    localparam logic [WR_CNT_W-1:0] WR_FULL_CNT = WR_CNT_W'(WR_FIFO_DEPTH);
    localparam logic [RD_CNT_W-1:0] RD_ALM_CNT  = RD_CNT_W'(RD_FIFO_DEPTH - ALMFULL_MARGIN);
    localparam logic [WR_CNT_W-1:0] WR_ALM_CNT  = WR_CNT_W'(WR_FIFO_DEPTH - ALMFULL_MARGIN);
    // Age thresholds are one less than the latency because the response
    // register adds the final cycle.
    localparam logic [15:0] RD_AGE_MIN = 16'(RD_LATENCY - 1);
    localparam logic [15:0] WR_AGE_MIN = 16'(WR_LATENCY - 1);

    // Backing store and queue payloads; none of these are reset.
    logic [511:0]             mem          [2**MEM_ADDR_BITS];
    logic [15:0]              rd_mdata_mem [RD_FIFO_DEPTH];
    logic [MEM_ADDR_BITS-1:0] rd_addr_mem  [RD_FIFO_DEPTH];
    logic [15:0]              rd_ts_mem    [RD_FIFO_DEPTH];
    logic [15:0]              wr_mdata_mem [WR_FIFO_DEPTH];
    logic [15:0]              wr_ts_mem    [WR_FIFO_DEPTH];

    logic [15:0]         ts_q, ts_d;
    logic [RD_PTR_W-1:0] rd_wptr_q, rd_wptr_d, rd_rptr_q, rd_rptr_d;
    logic [RD_CNT_W-1:0] rd_cnt_q, rd_cnt_d;
    logic [WR_PTR_W-1:0] wr_wptr_q, wr_wptr_d, wr_rptr_q, wr_rptr_d;
    logic [WR_CNT_W-1:0] wr_cnt_q, wr_cnt_d;
    logic                c0_valid_q, c0_valid_d;
    logic [15:0]         c0_mdata_q, c0_mdata_d;
    logic [511:0]        c0_data_q, c0_data_d;
    logic                c1_valid_q, c1_valid_d;
    logic [15:0]         c1_mdata_q, c1_mdata_d;
    logic                c0_alm_q, c0_alm_d;
    logic                c1_alm_q, c1_alm_d;
    logic                err_ovf_q, err_ovf_d;
    logic                err_len_q, err_len_d;

    logic                     rd_push, rd_pop, wr_push, wr_pop;
    logic [MEM_ADDR_BITS-1:0] c0_addr, c1_addr;
    logic                     c0_bad_len, c1_bad_len;
    logic                     unused_req_bits;

    // Header fields the responder does not interpret (vc_sel, req_type, sop,
    // upper address bits) are folded here so every input bit is referenced.
    assign unused_req_bits = ^{ccip_c0_tx, ccip_c1_tx};

    always_comb begin
        c0_addr    = ccip_c0_tx.hdr.address[MEM_ADDR_BITS-1:0];
        c1_addr    = ccip_c1_tx.hdr.address[MEM_ADDR_BITS-1:0];
        c0_bad_len = ccip_c0_tx.valid && (ccip_c0_tx.hdr.cl_len != eCL_LEN_1);
        c1_bad_len = ccip_c1_tx.valid && (ccip_c1_tx.hdr.cl_len != eCL_LEN_1);
        // Full is judged on the registered count, so a pop in the same cycle
        // does not open a slot for the incoming request.
        rd_push    = ccip_c0_tx.valid && (rd_cnt_q != RD_FULL_CNT);
        wr_push    = ccip_c1_tx.valid && (wr_cnt_q != WR_FULL_CNT);
        // Ages are modulo 2^16; legal latencies never approach the wrap.
        rd_pop     = (rd_cnt_q != '0) && ((ts_q - rd_ts_mem[rd_rptr_q]) >= RD_AGE_MIN);
        wr_pop     = (wr_cnt_q != '0) && ((ts_q - wr_ts_mem[wr_rptr_q]) >= WR_AGE_MIN);
    end

    always_comb begin
        ts_d       = ts_q + 16'd1;
        rd_wptr_d  = rd_push ? rd_wptr_q + RD_PTR_W'(1) : rd_wptr_q;
        rd_rptr_d  = rd_pop  ? rd_rptr_q + RD_PTR_W'(1) : rd_rptr_q;
        rd_cnt_d   = rd_cnt_q + RD_CNT_W'(rd_push) - RD_CNT_W'(rd_pop);
        wr_wptr_d  = wr_push ? wr_wptr_q + WR_PTR_W'(1) : wr_wptr_q;
        wr_rptr_d  = wr_pop  ? wr_rptr_q + WR_PTR_W'(1) : wr_rptr_q;
        wr_cnt_d   = wr_cnt_q + WR_CNT_W'(wr_push) - WR_CNT_W'(wr_pop);

        // The memory read happens before this edge's write lands, so a read
        // issued alongside a same-line write returns the old line.
        c0_valid_d = rd_pop;
        c0_mdata_d = rd_pop ? rd_mdata_mem[rd_rptr_q] : c0_mdata_q;
        c0_data_d  = rd_pop ? mem[rd_addr_mem[rd_rptr_q]] : c0_data_q;
        c1_valid_d = wr_pop;
        c1_mdata_d = wr_pop ? wr_mdata_mem[wr_rptr_q] : c1_mdata_q;

        c0_alm_d   = (rd_cnt_q >= RD_ALM_CNT);
        c1_alm_d   = (wr_cnt_q >= WR_ALM_CNT);
        err_ovf_d  = err_ovf_q | (ccip_c0_tx.valid && !rd_push) | (ccip_c1_tx.valid && !wr_push);
        err_len_d  = err_len_q | c0_bad_len | c1_bad_len;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ts_q       <= '0;
            rd_wptr_q  <= '0;
            rd_rptr_q  <= '0;
            rd_cnt_q   <= '0;
            wr_wptr_q  <= '0;
            wr_rptr_q  <= '0;
            wr_cnt_q   <= '0;
            c0_valid_q <= 1'b0;
            c0_mdata_q <= '0;
            c0_data_q  <= '0;
            c1_valid_q <= 1'b0;
            c1_mdata_q <= '0;
            c0_alm_q   <= 1'b0;
            c1_alm_q   <= 1'b0;
            err_ovf_q  <= 1'b0;
            err_len_q  <= 1'b0;
        end else begin
            ts_q       <= ts_d;
            rd_wptr_q  <= rd_wptr_d;
            rd_rptr_q  <= rd_rptr_d;
            rd_cnt_q   <= rd_cnt_d;
            wr_wptr_q  <= wr_wptr_d;
            wr_rptr_q  <= wr_rptr_d;
            wr_cnt_q   <= wr_cnt_d;
            c0_valid_q <= c0_valid_d;
            c0_mdata_q <= c0_mdata_d;
            c0_data_q  <= c0_data_d;
            c1_valid_q <= c1_valid_d;
            c1_mdata_q <= c1_mdata_d;
            c0_alm_q   <= c0_alm_d;
            c1_alm_q   <= c1_alm_d;
            err_ovf_q  <= err_ovf_d;
            err_len_q  <= err_len_d;
        end
    end

    // Storage keeps its contents across reset; writes are blocked while reset
    // is held so memory only changes for accepted requests.
    always_ff @(posedge clk) begin
        if (rd_push && !reset) begin
            rd_mdata_mem[rd_wptr_q] <= ccip_c0_tx.hdr.mdata;
            rd_addr_mem[rd_wptr_q]  <= c0_addr;
            rd_ts_mem[rd_wptr_q]    <= ts_q;
        end
        if (wr_push && !reset) begin
            mem[c1_addr]            <= ccip_c1_tx.data;
            wr_mdata_mem[wr_wptr_q] <= ccip_c1_tx.hdr.mdata;
            wr_ts_mem[wr_wptr_q]    <= ts_q;
        end
    end

    always_comb begin
        ccip_rx                   = '0;
        ccip_rx.c0TxAlmFull       = c0_alm_q;
        ccip_rx.c1TxAlmFull       = c1_alm_q;
        ccip_rx.c0.rspValid       = c0_valid_q;
        ccip_rx.c0.hdr.resp_type  = eRSP_RDLINE;
        ccip_rx.c0.hdr.mdata      = c0_mdata_q;
        ccip_rx.c0.data           = c0_data_q;
        ccip_rx.c1.rspValid       = c1_valid_q;
        ccip_rx.c1.hdr.resp_type  = eRSP_WRLINE;
        ccip_rx.c1.hdr.mdata      = c1_mdata_q;
        rd_outstanding            = rd_cnt_q;
        err_overflow              = err_ovf_q;
        err_cl_len                = err_len_q;
    end
endmodule
